// File: rtl/move_pkg.sv
// Shared move encoding for the undo stack: face/rotation types and the
// rotation algebra used for inversion, legality and (optionally) merging.
package move_pkg;

  localparam int FACE_W    = 3;
  localparam int NUM_FACES = 6;

  typedef enum logic [1:0] {
    ROT_CW  = 2'd0,
    ROT_CCW = 2'd1,
    ROT_DBL = 2'd2
  } rot_e;

  typedef enum logic [1:0] {
    REC  = 2'd0,
    LOAD = 2'd1,
    OUT  = 2'd2
  } state_e;

  function automatic logic [1:0] inv_rot(input logic [1:0] r);
    logic [1:0] res;
    res = r;
    if (r == ROT_CW)       res = ROT_CCW;
    else if (r == ROT_CCW) res = ROT_CW;
    return res;
  endfunction

  // Quarter-turn encoding: CW=1, double=2, CCW=3 (0 = identity).
  function automatic logic [1:0] rot_to_q(input logic [1:0] r);
    logic [1:0] q;
    q = 2'd0;
    if (r == ROT_CW)       q = 2'd1;
    else if (r == ROT_DBL) q = 2'd2;
    else if (r == ROT_CCW) q = 2'd3;
    return q;
  endfunction

  function automatic logic [1:0] q_to_rot(input logic [1:0] q);
    logic [1:0] r;
    r = ROT_CW;
    if (q == 2'd2)      r = ROT_DBL;
    else if (q == 2'd3) r = ROT_CCW;
    return r;
  endfunction

  function automatic logic is_legal(input logic [FACE_W-1:0] face, input logic [1:0] rot);
    return (face < FACE_W'(NUM_FACES)) && (rot != 2'd3);
  endfunction

endpackage

// File: rtl/move_lifo.sv
// History LIFO of {face,rot} entries. The pointer wraps modulo DEPTH;
// count alone decides full/empty, so the caller must not push when full.
module move_lifo #(
  parameter int DEPTH = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             replace_top,
  input  logic [4:0]       din,
  output logic [4:0]       top,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [4:0]       mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] top_ptr;

  assign top_ptr = ptr - PTR_W'(1);
  assign top     = mem[top_ptr];

  always_ff @(posedge clk) begin
    if (push)             mem[ptr]     <= din;
    else if (replace_top) mem[top_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr   <= ptr + PTR_W'(1);
      count <= count + CNT_W'(1);
    end else if (pop) begin
      ptr   <= top_ptr;
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/move_undo_stack.sv
// Records accepted moves and replays their inverses in reverse order.
// Optional move merging on the top entry is enabled by MOVE_MERGE_EN.
//
// state | meaning
// REC   | recording: accept moves, wait for undo_start
// LOAD  | register inverse of the top entry onto out_face/out_rot
// OUT   | present undo move, pop on handshake
module move_undo_stack
  import move_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_face,
  input  logic [1:0]       in_rot,
  input  logic             undo_start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_face,
  output logic [1:0]       out_rot,
  output logic             busy,
  output logic             undo_done,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  state_e           state, state_nxt;
  logic [4:0]       top, lifo_din;
  logic [2:0]       top_face;
  logic [1:0]       top_rot;
  logic             push, pop, replace;
  logic             legal, not_full, merge_ok, done_nxt;

  assign top_face = top[4:2];
  assign top_rot  = top[1:0];
  assign legal    = is_legal(in_face, in_rot);
  assign not_full = count < CNT_W'(DEPTH);

`ifdef MOVE_MERGE_EN
  logic       same_face;
  logic [1:0] q_sum;
  assign same_face = (count != '0) && (in_face == top_face);
  assign q_sum     = rot_to_q(top_rot) + rot_to_q(in_rot);
  assign merge_ok  = same_face;
`else
  assign merge_ok  = 1'b0;
`endif

  move_lifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_lifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .pop         (pop),
    .replace_top (replace),
    .din         (lifo_din),
    .top         (top),
    .count       (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= REC;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    replace   = 1'b0;
    done_nxt  = 1'b0;
    lifo_din  = {in_face, in_rot};
    case (state)
      REC: begin
        in_ready = rst && !undo_start && (not_full || merge_ok);
        if (undo_start) begin
          if (count != '0) state_nxt = LOAD;
          else             done_nxt  = 1'b1;
        end else if (in_valid && in_ready && legal) begin
`ifdef MOVE_MERGE_EN
          if (same_face) begin
            if (q_sum == 2'd0) begin
              pop = 1'b1;
            end else begin
              replace  = 1'b1;
              lifo_din = {top_face, q_to_rot(q_sum)};
            end
          end else begin
            push = 1'b1;
          end
`else
          push = 1'b1;
`endif
        end
      end
      LOAD: begin
        busy      = 1'b1;
        state_nxt = OUT;
      end
      OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          pop = 1'b1;
          if (count == CNT_W'(1)) begin
            state_nxt = REC;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = LOAD;
          end
        end
      end
      default: state_nxt = REC;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_face  <= '0;
      out_rot   <= '0;
      undo_done <= 1'b0;
      err       <= 1'b0;
    end else begin
      undo_done <= done_nxt;
      if (state == LOAD) begin
        out_face <= top_face;
        out_rot  <= inv_rot(top_rot);
      end
      // Illegal moves still complete the handshake; they only raise err.
      if (in_valid && in_ready && !legal) err <= 1'b1;
    end
  end

endmodule

// File: doc/move_undo_stack.md
Name: move_undo_stack

Overview:
- Consumer of the face/rotation move stream produced by the scramble generator.
- Records every accepted move on a LIFO history stack.
- On request, replays the inverse of each recorded move in reverse order, producing the solve sequence that undoes the scramble.
- Sits between the move source and the cube-state updater; the updater drains undo moves through a valid/ready port.

Parameters:
- DEPTH, 32, number of history entries; must be a power of 2, ≥2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  a move is offered.
- in_ready  out  1  the block accepts the offered move this cycle.
- in_face  in  3  face 0..5; values 6 and 7 are illegal.
- in_rot  in  2  0=CW, 1=CCW, 2=double; 3 is illegal.
- undo_start  in  1  single-cycle request to replay the history.
- out_valid  out  1  an undo move is presented.
- out_ready  in  1  the downstream accepts the undo move.
- out_face  out  3  face of the undo move.
- out_rot  out  2  rotation of the undo move (inverse of the recorded move).
- busy  out  1  high in any undo state.
- undo_done  out  1  one-cycle pulse when replay completes.
- count  out  CNT_W  current stack occupancy.
- err  out  1  sticky flag: an illegal move was received.

Behaviour:
- Reset (async, rst=0): state=REC, stack empty, count=0, in_ready=0 while in reset, out_valid=0, out_face=0, out_rot=0, busy=0, undo_done=0, err=0. Reset mid-replay aborts the replay and discards all history.
- in_ready = (state==REC) && (count<DEPTH) && !undo_start. Combinational.
- Accept occurs when in_valid && in_ready.
  - Legal move: pushed; count increments on the next edge.
  - Illegal move (face>5 or rot==3): handshake completes, move is discarded, err<=1.
- States: REC, LOAD, OUT.
- REC:
  - undo_start with count>0 -> LOAD.
  - undo_start with count==0 -> undo_done=1 on the next cycle, stay in REC.
  - undo_start has priority over a same-cycle in_valid; no push occurs that cycle.
- LOAD (1 cycle): register the top entry.
  - out_face <= top face.
  - out_rot <= inverse of top rotation: CW->CCW, CCW->CW, double->double.
  - Go to OUT.
- OUT:
  - out_valid=1; out_face and out_rot held stable until the handshake.
  - On out_valid && out_ready: pop, count decrements.
  - If count was 1 -> REC, out_valid=0, undo_done pulses for exactly the cycle after the handshake.
  - Otherwise -> LOAD.
  - Throughput: one undo move per 2 cycles minimum.
- busy=1 in LOAD and OUT.
- undo_start received in LOAD or OUT is ignored.
- Full (count==DEPTH): in_ready=0; there is no overwrite and no wrap.
- Stack pointer arithmetic is modulo DEPTH. count is the only full/empty authority.

Optional Feature:
- Macro MOVE_MERGE_EN.
- Defined:
  - When a legal move's face equals the top entry's face and count>0, merge it into the top entry instead of pushing.
  - Encode rotations as quarter turns: CW=1, double=2, CCW=3.
  - sum = (q_top + q_in) mod 4.
  - sum==0 -> pop (count-1).
  - sum!=0 -> replace the top rotation (1->CW, 2->double, 3->CCW); count is unchanged.
  - A merge is allowed even when the stack is full: in_ready stays 1 if the incoming face equals the top face.
- Undefined: every legal move is pushed; no merging.

Decomposition:
- Package move_pkg:
  - face width constant and NUM_FACES=6.
  - rotation typedef {ROT_CW, ROT_CCW, ROT_DBL}.
  - function inv_rot.
  - functions rot_to_q and q_to_rot.
  - function is_legal(face, rot).
- Sub-module move_lifo (DEPTH entries of 5 bits): push, pop, replace_top, top, count.
- The FSM and handshake logic live in move_undo_stack.

Test Plan:
- Push (F0,CW), (F3,double), (F5,CCW), then pulse undo_start with out_ready=1.
  - Required outputs in order: (F5,CW), (F3,double), (F0,CCW).
  - undo_done pulses once; count ends at 0.
- Push DEPTH legal moves.
  - in_ready=0 at count=DEPTH; a further in_valid is not accepted.
- Offer (F6,CW), then (F2,rot 3).
  - Both handshakes complete, count stays 0, err=1 and stays 1 until reset.
- During OUT, hold out_ready=0 for 5 cycles.
  - out_valid, out_face, out_rot stay stable; no pop occurs.
- Assert rst low mid-replay with 3 entries left.
  - All outputs return to reset values immediately.
  - After release, undo_start gives undo_done with no moves output.
- With MOVE_MERGE_EN:
  - Push (F1,CW), (F1,CW) -> count=1 with top (F1,double).
  - Then push (F1,double) -> count=0.
  - Then push (F2,CW), (F2,double) -> top (F2,CCW).
